booth_pe_bank: RTL and testbench

//  Parametrised successor of the shift-subtract systolic PE. Each PE holds a DEPTH-entry bank of

---
 rtl/booth_pe_bank.sv | 209 ++++++++++++++++++++
 tb/tb_booth_pe_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/booth_pe_bank.sv
// booth_pe_bank
//   Systolic processing element holding a DEPTH-entry bank of Booth-style
//   weights w = 2^p - 2^n. On every valid activation it computes
//   (A<<p) - (A<<n) + bias with the next weight of the bank and passes the
//   result down the column. Control words loaded from the top bus select
//   unsigned/signed activations and load or run the bank.
//
//   Optional feature macro: BOOTH_PE_SAT_EN
//     defined   -> product clamped to the signed NB-1-bit range, sticky ovf
//     undefined -> product wraps mod 2^(NB-1), ovf held at 0
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   a_in       in   NA   activation from left
//   a_vld_in   in   1    a_in valid
//   b_in       in   NB   weight / bias / control word from top
//   a_out      out  NA   registered a_in to right
//   a_vld_out  out  1    registered a_vld_in
//   d_out      out  NB   registered product / forwarded word to bottom
//   ovf        out  1    sticky saturation flag
module booth_pe_bank #(
  parameter int NA    = 8,
  parameter int NSH   = 3,
  parameter int NID   = 7,
  parameter int DEPTH = 4,
  parameter int NB    = 27,
  parameter int IDX   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NA-1:0] a_in,
  input  logic          a_vld_in,
  input  logic [NB-1:0] b_in,
  output logic [NA-1:0] a_out,
  output logic          a_vld_out,
  output logic [NB-1:0] d_out,
  output logic          ovf
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = 2 * NSH;
  localparam logic [NID-1:0] IDX_L   = NID'(IDX);
  localparam logic [SW-1:0]  LAST    = SW'(DEPTH - 1);

  localparam logic [2:0] C_RSET = 3'd1;
  localparam logic [2:0] C_ALT2 = 3'd2;
  localparam logic [2:0] C_INTM = 3'd3;
  localparam logic [2:0] C_LOAD = 3'd4;
  localparam logic [2:0] C_MULT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MULT = 2'd2
  } state_t;

  state_t          state;
  logic            mode_int;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   load_cnt;
  logic [NW-1:0]   bank [DEPTH];

  // Input word decode
  logic            is_ctrl;
  logic            is_wt;
  logic [2:0]      code;
  logic [NW-1:0]   wt;
  logic [SW-1:0]   slot;
  logic [NID-1:0]  idx;
  logic            slot_ok;

  assign code    = b_in[2:0];
  assign is_ctrl = b_in[NB-1] && (b_in[5:3] == b_in[2:0]);
  assign is_wt   = b_in[NB-1] && !is_ctrl;
  assign wt      = b_in[NW-1:0];
  assign slot    = b_in[NW +: SW];
  assign idx     = b_in[NW+SW +: NID];
  // Widen by one bit so DEPTH itself is representable for the compare.
  assign slot_ok = ({1'b0, slot} < (SW+1)'(DEPTH));

  // Datapath: current weight split into its two shift amounts
  logic [NW-1:0]   cur_w;
  logic [NSH-1:0]  sh_p;
  logic [NSH-1:0]  sh_n;
  logic [NB-2:0]   prod;
  logic            sat_hit;

  assign cur_w = bank[ptr];
  assign sh_p  = cur_w[NW-1:NSH];
  assign sh_n  = cur_w[NSH-1:0];

`ifdef BOOTH_PE_SAT_EN
  // One guard bit above the NB-1-bit result exposes signed overflow.
  logic [NB-1:0] a_ext;
  logic [NB-1:0] bias_ext;
  logic [NB-1:0] sum_full;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    a_ext    = {{(NB-NA){mode_int & a_in[NA-1]}}, a_in};
    bias_ext = {b_in[NB-2], b_in[NB-2:0]};
    sum_full = (a_ext << sh_p) - (a_ext << sh_n) + bias_ext;
    sat_hit  = (sum_full[NB-1] != sum_full[NB-2]);
    prod     = sum_full[NB-2:0];
    if (sat_hit) begin
      // Clamp toward the sign of the true (guard-bit) result.
      prod = sum_full[NB-1] ? {1'b1, {(NB-2){1'b0}}} : {1'b0, {(NB-2){1'b1}}};
    end
  end
`else
  logic [NB-2:0] a_ext;

  always_comb begin
    a_ext   = {{(NB-1-NA){mode_int & a_in[NA-1]}}, a_in};
    prod    = (a_ext << sh_p) - (a_ext << sh_n) + b_in[NB-2:0];
    sat_hit = 1'b0;
  end
`endif

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      d_out     <= '0;
      ovf       <= 1'b0;
      state     <= S_IDLE;
      mode_int  <= 1'b0;
      ptr       <= '0;
      load_cnt  <= '0;
      // NOTE: the bank is cleared on reset because a MULT issued straight
      // after reset must see zero weights; it is small enough to stay in flops.
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;

      if (is_ctrl && code == C_RSET) begin
        // Column-wide soft reset; ovf survives so a host can still read it.
        d_out    <= b_in;
        state    <= S_IDLE;
        mode_int <= 1'b0;
        ptr      <= '0;
        load_cnt <= '0;
        for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (is_ctrl) begin
              d_out <= b_in;
              case (code)
                C_ALT2: mode_int <= 1'b0;
                C_INTM: mode_int <= 1'b1;
                C_LOAD: begin
                  state    <= S_LOAD;
                  load_cnt <= '0;
                end
                C_MULT: begin
                  state <= S_MULT;
                  ptr   <= '0;
                end
                default: ;
              endcase
            end else begin
              d_out <= '0;
            end
          end

          S_LOAD: begin
            if (is_wt && idx == IDX_L && slot_ok) begin
              // Word addressed to this row: consume it.
              bank[slot] <= wt;
              d_out      <= '0;
              load_cnt   <= load_cnt + 1'b1;
              if (load_cnt == LAST) state <= S_IDLE;
            end else begin
              // Words for other rows (and rejected slots) travel on down.
              d_out <= b_in;
              if (is_ctrl && code == C_ALT2) state <= S_IDLE;
            end
          end

          S_MULT: begin
            if (is_ctrl) begin
              d_out <= b_in;
              if (code == C_ALT2) begin
                state <= S_IDLE;
                ptr   <= '0;
              end
            end else if (a_vld_in) begin
              d_out <= {1'b0, prod};
              ptr   <= (ptr == LAST) ? '0 : ptr + 1'b1;
              if (sat_hit) ovf <= 1'b1;
            end else begin
              // No activation: the bias passes straight through.
              d_out <= {1'b0, b_in[NB-2:0]};
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_pe_bank.sv
// Directed testbench for booth_pe_bank (default parameters: DEPTH=4, IDX=0).
// Expected values are hand-computed constants; saturation-dependent ones
// follow BOOTH_PE_SAT_EN.
module tb_booth_pe_bank;

  logic        clk;
  logic        rst;
  logic [7:0]  a_in;
  logic        a_vld_in;
  logic [26:0] b_in;
  logic [7:0]  a_out;
  logic        a_vld_out;
  logic [26:0] d_out;
  logic        ovf;

  int n_asserts = 0;
  int n_fails   = 0;

  booth_pe_bank dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .a_vld_in  (a_vld_in),
    .b_in      (b_in),
    .a_out     (a_out),
    .a_vld_out (a_vld_out),
    .d_out     (d_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BOOTH_PE_SAT_EN
  localparam logic [26:0] EXP_T5_D   = 27'h1FFFFFF;
  localparam logic [31:0] EXP_T5_OVF = 32'd1;
`else
  localparam logic [26:0] EXP_T5_D   = 27'h200001D;
  localparam logic [31:0] EXP_T5_OVF = 32'd0;
`endif

  function automatic logic [26:0] ctrl(input logic [2:0] c);
    return {1'b1, 20'b0, c, c};
  endfunction

  function automatic logic [26:0] wword(input logic [6:0] idx, input logic [1:0] slot,
                                       input logic [2:0] p, input logic [2:0] n);
    return {1'b1, 11'b0, idx, slot, p, n};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic [7:0] a, input logic v, input logic [26:0] b);
    @(negedge clk);
    a_in     = a;
    a_vld_in = v;
    b_in     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    a_in     = '0;
    a_vld_in = 1'b0;
    b_in     = '0;

    // Reset state
    @(negedge clk);
    check("rst_d_out",     32'(d_out),     32'h0);
    check("rst_a_out",     32'(a_out),     32'h0);
    check("rst_a_vld_out", 32'(a_vld_out), 32'h0);
    check("rst_ovf",       32'(ovf),       32'h0);
    rst = 1'b0;

    // T2: bank load with an interleaved word for row 1
    step(8'd0, 1'b0, ctrl(3'd4));
    check("t2_load_fwd", 32'(d_out), 32'h4000024);
    step(8'd0, 1'b0, wword(7'd0, 2'd0, 3'd3, 3'd1));
    check("t2_acc0", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, wword(7'd1, 2'd0, 3'd5, 3'd1));
    check("t2_idx1_fwd", 32'(d_out), 32'h4000129);
    step(8'd0, 1'b0, wword(7'd0, 2'd1, 3'd2, 3'd0));
    check("t2_acc1", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, wword(7'd0, 2'd2, 3'd1, 3'd2));
    check("t2_acc2", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, wword(7'd0, 2'd3, 3'd0, 3'd3));
    check("t2_acc3", 32'(d_out), 32'h0);
    // Back in IDLE: a plain word is squashed rather than forwarded.
    step(8'd0, 1'b1, 27'h0000123);
    check("t2_idle", 32'(d_out), 32'h0);

    // T3: uint multiply cycling the bank (w = 6, 3, -2, -7)
    step(8'd0, 1'b0, ctrl(3'd2));
    check("t3_alt2_fwd", 32'(d_out), 32'h4000012);
    step(8'd0, 1'b0, ctrl(3'd5));
    check("t3_mult_fwd", 32'(d_out), 32'h400002D);
    step(8'd5, 1'b1, 27'd10);
    check("t3_w0", 32'(d_out), 32'd40);
    check("t3_a_out", 32'(a_out), 32'd5);
    check("t3_a_vld_out", 32'(a_vld_out), 32'd1);
    step(8'd5, 1'b1, 27'd10);
    check("t3_w1", 32'(d_out), 32'd25);
    step(8'd5, 1'b1, 27'd10);
    check("t3_w2", 32'(d_out), 32'd0);
    step(8'd5, 1'b1, 27'd10);
    check("t3_w3_neg", 32'(d_out), 32'h3FFFFE7);
    step(8'd5, 1'b1, 27'd10);
    check("t3_wrap_w0", 32'(d_out), 32'd40);

    // T6: bias bypass holds ptr; stray control in MULT is forwarded only
    step(8'd5, 1'b0, 27'd7);
    check("t6_bypass", 32'(d_out), 32'd7);
    check("t6_a_vld_out", 32'(a_vld_out), 32'd0);
    step(8'd5, 1'b1, 27'd10);
    check("t6_ptr_held_w1", 32'(d_out), 32'd25);
    step(8'd0, 1'b0, ctrl(3'd4));
    check("t6_mult_ctrl_fwd", 32'(d_out), 32'h4000024);
    step(8'd5, 1'b1, 27'd10);
    check("t6_still_mult_w2", 32'(d_out), 32'd0);
    step(8'd0, 1'b0, ctrl(3'd2));
    check("t6_mult_exit", 32'(d_out), 32'h4000012);

    // T4 + T6 abort: signed mode, partial reload of slot 0 with {2,0}
    step(8'd0, 1'b0, ctrl(3'd3));
    check("t4_intm_fwd", 32'(d_out), 32'h400001B);
    step(8'd0, 1'b0, ctrl(3'd4));
    step(8'd0, 1'b0, wword(7'd0, 2'd0, 3'd2, 3'd0));
    check("t4_acc0", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, ctrl(3'd2));
    check("t6_abort_fwd", 32'(d_out), 32'h4000012);
    step(8'd0, 1'b0, 27'h0000055);
    check("t6_abort_idle", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, ctrl(3'd5));
    step(8'hFD, 1'b1, 27'd0);
    check("t4_int_neg9", 32'(d_out), 32'h3FFFFF7);
    step(8'hFD, 1'b1, 27'd100);
    check("t4_int_w1", 32'(d_out), 32'd91);

    // T5: overflow with bank[0] = {3,1}
    step(8'd0, 1'b0, ctrl(3'd2));
    step(8'd0, 1'b0, ctrl(3'd4));
    step(8'd0, 1'b0, wword(7'd0, 2'd0, 3'd3, 3'd1));
    step(8'd0, 1'b0, ctrl(3'd2));
    step(8'd0, 1'b0, ctrl(3'd5));
    step(8'd5, 1'b1, 27'h1FFFFFF);
    check("t5_prod", 32'(d_out), 32'(EXP_T5_D));
    check("t5_ovf", 32'(ovf), EXP_T5_OVF);
    step(8'd5, 1'b1, 27'd0);
    check("t5_next_w1", 32'(d_out), 32'd15);
    check("t5_ovf_sticky", 32'(ovf), EXP_T5_OVF);

    // Soft reset: ovf kept, bank/state/mode cleared
    step(8'd0, 1'b0, ctrl(3'd1));
    check("rset_ovf_kept", 32'(ovf), EXP_T5_OVF);
    step(8'd0, 1'b0, 27'h0000055);
    check("rset_idle", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, ctrl(3'd5));
    step(8'd5, 1'b1, 27'd10);
    check("rset_bank_clear", 32'(d_out), 32'd10);

    // T1: asynchronous reset mid-MULT
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_async_d_out", 32'(d_out), 32'h0);
    check("t1_async_a_out", 32'(a_out), 32'h0);
    check("t1_async_a_vld", 32'(a_vld_out), 32'h0);
    check("t1_async_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    a_vld_in = 1'b0;
    step(8'd7, 1'b1, 27'h0000033);
    check("t1_idle_after_rst", 32'(d_out), 32'h0);
    step(8'd0, 1'b0, ctrl(3'd5));
    step(8'd7, 1'b1, 27'd3);
    check("t1_mult_bias_only", 32'(d_out), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
